dac_seq_ctrl: RTL and testbench
===============================

Name: dac_seq_ctrl

Overview:
Frame sequencer for the 12-bit DAC serial path. It fetches waveform words from a synchronous sample RAM and hands them one frame at a time to the downstream DAC serializer, which shifts 12 bits MSB-first over 13 cycles. It also shares that serializer between waveform playback and a single-word configuration requester, and it generates the DAC frame strobe.

Parameters:
DATA_W, 12, word width and serializer frame length in bits
ADDR_W, 8, sample RAM address width
GAP, 2, idle cycles inserted after every frame (0 allowed)

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  pulse: begin playback of length words from base_addr
stop  in  1  pulse: end playback at next frame boundary
base_addr  in  ADDR_W  first playback address, sampled on accepted start
length  in  ADDR_W  word count, sampled on accepted start; 0 = no frames
cfg_req  in  1  level: config word pending
cfg_data  in  DATA_W  config word, must be stable while cfg_req=1
cfg_ack  out  1  one-cycle pulse: config word loaded
mem_addr  out  ADDR_W  registered RAM address
mem_rdata  in  DATA_W  RAM data, valid 2 cycles after mem_addr changes
ser_en  out  1  serializer start strobe
ser_data  out  DATA_W  serializer parallel word
dac_sync_n  out  1  active-low frame strobe aligned to serial bits
busy  out  1  high whenever FSM not in IDLE
done  out  1  one-cycle pulse: playback finished or stopped

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: cfg_ack=0, mem_addr=0, ser_en=0, ser_data=0, dac_sync_n=1, busy=0, done=0; FSM=IDLE; playback armed flag, stop flag and index cleared.
- Reset mid-frame aborts immediately. The serializer shares the same reset, so no partial-frame recovery is needed.
- All outputs are registered.
- FSM states: IDLE, ARB, FETCH, WAIT, CAPT, LOAD, SHIFT, GAP.
- IDLE:
  - start sets the armed flag and latches base_addr/length; index=0.
  - If length=0, done pulses the next cycle and the armed flag stays clear.
  - Go to ARB when cfg_req=1 or armed=1.
  - start while busy is ignored.
- ARB (the frame boundary):
  - cfg_req has priority: go to CAPT with source=cfg.
  - Otherwise, if armed and stop flag clear: go to FETCH.
  - Otherwise, if armed and stop flag set: clear armed, pulse done, go to IDLE.
  - Otherwise: go to IDLE.
- FETCH: mem_addr <= base+index, wrapping modulo 2^ADDR_W.
- WAIT: the RAM samples the address.
- CAPT: ser_data <= mem_rdata (play) or cfg_data (cfg); ser_en <= 1.
- LOAD:
  - ser_en high for exactly this one cycle.
  - cfg_ack pulses if source=cfg.
  - If source=play, index increments.
  - ser_data is held unchanged from LOAD until the next CAPT.
- SHIFT:
  - Lasts 13 cycles, counter 0..12; cycle 1 is the first after LOAD.
  - dac_sync_n is low in SHIFT cycles 2..13 relative to LOAD=0, i.e. exactly the 12 cycles carrying serial bits MSB..LSB.
  - It returns high on cycle 14.
- GAP:
  - Lasts GAP cycles, then ARB. With GAP=0, go straight to ARB.
  - On entering GAP (play source), if index == length: clear armed, pulse done.
- stop:
  - A pulse in any state while armed sets the stop flag.
  - An in-flight frame always completes; a frame is never truncated.
  - A stop flag already set is cleared when done pulses.
  - stop while not armed is ignored.
- Simultaneous events:
  - start and cfg_req together in IDLE: the config frame goes first, then playback.
  - cfg_req asserted during playback is inserted at the next ARB and does not consume a playback address.
- Frame period: ARB→LOAD takes 4 cycles for play, 2 for cfg. Total play period = 1+3+1+13+GAP cycles.
- The serializer is guaranteed idle at every LOAD because SHIFT covers its full 13-cycle busy window.

Test Plan:
1. base=0x10, length=3, RAM[n]=0xA00+n, GAP=2 → three ser_en pulses carrying 0xA10,0xA11,0xA12; each dac_sync_n low for exactly 12 cycles; done pulses once after the third frame; busy then drops.
2. base=0xFE, length=4 → mem_addr sequence 0xFE,0xFF,0x00,0x01 (wrap).
3. Playback of length=5 with cfg_req (cfg_data=0x3C5) raised during frame 2 → frame 3 carries 0x3C5 with a cfg_ack pulse; playback resumes at word 2; total of 6 frames.
4. stop pulsed in the middle of frame 2 of length=10 → frame 2 completes all 12 serial bits; no frame 3; done pulses; mem_addr is not advanced further.
5. start with length=0 → done the following cycle; ser_en never asserts. Also: start re-pulsed while busy has no effect.
6. reset asserted in SHIFT cycle 6 → the next cycle shows all outputs at reset values and FSM=IDLE; a new start afterwards plays from index 0.

Source files
------------

// File: rtl/dac_seq_ctrl_if.sv
// Control, RAM and serializer signals of the DAC frame sequencer.
// master drives requests and RAM data; slave is the sequencer.
interface dac_seq_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              cfg_req;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              ser_en;
  logic [DATA_W-1:0] ser_data;
  logic              dac_sync_n;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, base_addr, length,
    output cfg_req, cfg_data, mem_rdata,
    input  cfg_ack, mem_addr, ser_en, ser_data,
    input  dac_sync_n, busy, done
  );

  modport slave (
    input  start, stop, base_addr, length,
    input  cfg_req, cfg_data, mem_rdata,
    output cfg_ack, mem_addr, ser_en, ser_data,
    output dac_sync_n, busy, done
  );
endinterface

// File: rtl/dac_seq_ctrl.sv
// Frame sequencer: feeds sample RAM words or a config word to the
// DAC serializer one frame at a time and generates the frame strobe.
module dac_seq_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8,
  parameter int GAP    = 2
) (
  input logic           clk,
  input logic           reset,
  dac_seq_ctrl_if.slave bus
);
  localparam int CMAX  = (GAP > DATA_W) ? GAP : DATA_W;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_FETCH, S_WAIT,
    S_CAPT, S_LOAD, S_SHIFT, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic              stop_q, stop_d;
  logic              src_cfg_q, src_cfg_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ser_en_q, ser_en_d;
  logic [DATA_W-1:0] ser_data_q, ser_data_d;
  logic              sync_n_q, sync_n_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    stop_d     = stop_q;
    src_cfg_d  = src_cfg_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ser_data_d = ser_data_q;
    ser_en_d   = 1'b0;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    sync_n_d   = 1'b1;

    if (bus.stop && armed_q) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d = bus.base_addr;
          len_d  = bus.length;
          idx_d  = '0;
          if (bus.length == '0) done_d  = 1'b1;
          else                  armed_d = 1'b1;
        end
        if (bus.cfg_req || armed_d) state_d = S_ARB;
      end
      S_ARB: begin
        if (bus.cfg_req) begin
          src_cfg_d = 1'b1;
          state_d   = S_CAPT;
        end else if (armed_q && !stop_q) begin
          src_cfg_d = 1'b0;
          state_d   = S_FETCH;
        end else if (armed_q) begin
          armed_d = 1'b0;
          stop_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        addr_d  = base_q + idx_q;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        ser_data_d = src_cfg_q ? bus.cfg_data : bus.mem_rdata;
        ser_en_d   = 1'b1;
        ack_d      = src_cfg_q;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (!src_cfg_q) idx_d = idx_q + ADDR_W'(1);
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // strobe low while the 12 data bits are on the wire
        sync_n_d = (cnt_q == SH_LAST);
        if (cnt_q == SH_LAST) begin
          cnt_d = '0;
          if (!src_cfg_q && idx_q == len_q) begin
            armed_d = 1'b0;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end
          state_d = (GAP == 0) ? S_ARB : S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_ARB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b0;
      stop_q     <= 1'b0;
      src_cfg_q  <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      ser_en_q   <= 1'b0;
      ser_data_q <= '0;
      sync_n_q   <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      stop_q     <= stop_d;
      src_cfg_q  <= src_cfg_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ser_en_q   <= ser_en_d;
      ser_data_q <= ser_data_d;
      sync_n_q   <= sync_n_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.cfg_ack    = ack_q;
  assign bus.mem_addr   = addr_q;
  assign bus.ser_en     = ser_en_q;
  assign bus.ser_data   = ser_data_q;
  assign bus.dac_sync_n = sync_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Bench for dac_seq_ctrl: table and random playback runs against a
// frame-list model, plus hand sequences for reset and length 0.
module tb_dac_seq_ctrl;
  localparam int GAP_TB = 2;
  localparam logic [11:0] CFG_WORD = 12'h3C5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_seq_ctrl_if #(.DATA_W(12), .ADDR_W(8)) bus ();

  dac_seq_ctrl #(.DATA_W(12), .ADDR_W(8), .GAP(GAP_TB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [11:0] ram [256];
  always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    int cfg_f;
    int stop_f;
    int rs_f;
    int exp_frames;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // written only by the driver/monitor process
  logic [12:0] obs_q[$];
  logic [7:0]  addr_q[$];
  int tq[$];
  int runs[$];
  int cyc = 0, play_seen = 0, done_seen = 0, low_run = 0;
  int stop_cd = 0, cfg_cd = 0, go_done = 0;

  // written only by the main test process
  int stop_f = -1, cfg_f = -1, rs_f = -1, go_cnt = 0;
  logic [7:0] go_base = '0, go_len = '0;
  bit go_cfg = 1'b0;
  logic [12:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // drives every bus input at negedge and records observed frames
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.cfg_req = 1'b0;
    bus.cfg_data = '0;
    bus.base_addr = '0;
    bus.length = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      if (bus.cfg_ack) bus.cfg_req = 1'b0;
      if (go_done != go_cnt) begin
        obs_q.delete(); addr_q.delete();
        tq.delete(); runs.delete();
        play_seen = 0; done_seen = 0; low_run = 0;
        stop_cd = 0; cfg_cd = 0;
        bus.base_addr = go_base;
        bus.length = go_len;
        bus.start = 1'b1;
        if (go_cfg) begin
          bus.cfg_data = CFG_WORD;
          bus.cfg_req = 1'b1;
        end
        go_done = go_cnt;
      end
      if (bus.done) done_seen++;
      if (!bus.dac_sync_n) low_run++;
      else if (low_run != 0) begin
        runs.push_back(low_run);
        low_run = 0;
      end
      if (stop_cd > 0) begin
        stop_cd--;
        if (stop_cd == 0) bus.stop = 1'b1;
      end
      if (cfg_cd > 0) begin
        cfg_cd--;
        if (cfg_cd == 0) begin
          bus.cfg_data = CFG_WORD;
          bus.cfg_req = 1'b1;
        end
      end
      if (bus.ser_en) begin
        obs_q.push_back({bus.cfg_ack, bus.ser_data});
        tq.push_back(cyc);
        if (!bus.cfg_ack) begin
          addr_q.push_back(bus.mem_addr);
          if (play_seen == stop_f) stop_cd = 6;
          if (play_seen == cfg_f) cfg_cd = 6;
          if (play_seen == rs_f) begin
            bus.start = 1'b1;
            bus.base_addr = 8'h80;
            bus.length = 8'd7;
          end
          play_seen++;
        end
      end
    end
  end

  task automatic kick(input logic [7:0] b, input logic [7:0] l,
                      input bit c);
    go_base = b;
    go_len = l;
    go_cfg = c;
    go_cnt++;
    wait (go_done == go_cnt);
  endtask

  task automatic run_vec(input vec_t v);
    int np, n, per;
    bit ok;
    stop_f = v.stop_f;
    cfg_f = v.cfg_f;
    rs_f = v.rs_f;
    np = v.len;
    if (v.stop_f >= 0 && v.stop_f + 1 < np) np = v.stop_f + 1;
    exp_q.delete();
    if (v.cfg_f == -2) exp_q.push_back({1'b1, CFG_WORD});
    for (int i = 0; i < np; i++) begin
      exp_q.push_back({1'b0, ram[8'(v.base + i)]});
      if (v.cfg_f == i) exp_q.push_back({1'b1, CFG_WORD});
    end
    kick(v.base, v.len, v.cfg_f == -2);
    n = 0;
    ok = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (n >= 3 && !bus.busy && stop_cd == 0 && cfg_cd == 0 &&
          !bus.cfg_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("run_timeout", ok, 1);
    repeat (2) @(negedge clk);
    chk("done_count", done_seen, 1);
    if (v.exp_frames >= 0) chk("frames_tbl", obs_q.size(), v.exp_frames);
    chk("frames_model", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk("frame_word", obs_q[i], exp_q[i]);
    chk("fetch_count", addr_q.size(), np);
    for (int i = 0; i < addr_q.size() && i < np; i++)
      chk("mem_addr", addr_q[i], 8'(v.base + i));
    if (np > 0) chk("final_addr", bus.mem_addr, 8'(v.base + np - 1));
    chk("sync_runs", runs.size(), obs_q.size());
    foreach (runs[i]) chk("sync_low_len", runs[i], 12);
    for (int i = 1; i < tq.size() && i < exp_q.size(); i++) begin
      per = 14 + GAP_TB + (exp_q[i][12] ? 2 : 4);
      chk("frame_period", tq[i] - tq[i-1], per);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cfg_ack"}, bus.cfg_ack, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_ser_en"}, bus.ser_en, 0);
    chk({tag, "_ser_data"}, bus.ser_data, 0);
    chk({tag, "_sync_n"}, bus.dac_sync_n, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int n, L;
    tbl[0] = '{8'h10, 8'd3,  -1, -1,  0, 3};
    tbl[1] = '{8'hFE, 8'd4,  -1, -1, -1, 4};
    tbl[2] = '{8'h20, 8'd5,   1, -1, -1, 6};
    tbl[3] = '{8'h30, 8'd10, -1,  1, -1, 2};
    tbl[4] = '{8'h00, 8'd0,  -1, -1, -1, 0};
    tbl[5] = '{8'h50, 8'd2,   1, -1, -1, 3};
    tbl[6] = '{8'h60, 8'd1,  -1,  0, -1, 1};
    tbl[7] = '{8'h10, 8'd2,  -2, -1, -1, 3};
    for (int i = 0; i < 256; i++) ram[i] = 12'hA00 + 12'(i);

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;

    // length 0: done the following cycle, never busy
    kick(8'h33, 8'd0, 1'b0);
    @(negedge clk);
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    @(negedge clk);
    chk("len0_done_pulse", bus.done, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // reset in SHIFT cycle 6 aborts the frame
    stop_f = -1; cfg_f = -1; rs_f = -1;
    kick(8'h40, 8'd5, 1'b0);
    n = 0;
    while (!bus.ser_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_load_seen", bus.ser_en, 1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    reset = 1'b0;
    run_vec('{8'h40, 8'd2, -1, -1, -1, 2});

    for (int i = 0; i < 256; i++) ram[i] = 12'($urandom);
    for (int r = 0; r < 10; r++) begin
      v.base = 8'($urandom);
      L = $urandom_range(0, 6);
      v.len = 8'(L);
      v.cfg_f = -1;
      v.stop_f = -1;
      v.rs_f = -1;
      if (L > 0) begin
        if ($urandom_range(0, 1) == 1) v.cfg_f = $urandom_range(0, L - 1);
        if ($urandom_range(0, 1) == 1) v.stop_f = $urandom_range(0, L - 1);
        if ($urandom_range(0, 1) == 1) v.rs_f = 0;
      end
      v.exp_frames = -1;
      run_vec(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
